// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller:
// stall bus patterns and sequencing FSM states.
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS_W-1:0] STALL_LU   = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_MC   = 6'b001111;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_LU  = 2'd1,
        S_MC  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the pipeline stages and the stall controller.
// master = pipeline side, slave = controller side.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);

    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   br_e_i;
    logic [31:0]            br_addr_i;
    logic                   next_is_indelayslot;
    logic [STALL_BUS_W-1:0] stall;
    logic                   br_e_o;
    logic [31:0]            br_addr_o;
    logic                   is_indelayslot;
    logic [CNT_W-1:0]       stall_cnt;
    logic                   mc_timeout;

    modport master (
        output stallreq_id, stallreq_ex, br_e_i, br_addr_i,
        output next_is_indelayslot,
        input  stall, br_e_o, br_addr_o, is_indelayslot,
        input  stall_cnt, mc_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, br_e_i, br_addr_i,
        input  next_is_indelayslot,
        output stall, br_e_o, br_addr_o, is_indelayslot,
        output stall_cnt, mc_timeout
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter with enable, synchronous clear and saturation at MAX.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing: merges ID/EX stall requests, gates branch
// redirects, tracks delay slots, counts stalls and watches EX holds.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32,
    parameter int MC_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int MC_W = $clog2(MC_MAX + 1);
    localparam logic [MC_W-1:0] MC_TOP  = MC_W'(MC_MAX);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_MAX - 1);

    state_e             r_state;
    state_e             w_next;
    logic               r_lu_seen;
    logic               r_inslot;
    logic               r_to;
    logic [STALL_W-1:0] w_stall;
    logic               w_id_req;
    logic               w_mc_en;
    logic               w_br;
    logic [MC_W-1:0]    w_mc_cnt;
    logic [CNT_W-1:0]   w_stall_cnt;

    // A held load-use request yields a single bubble per assertion
    assign w_id_req = bus.stallreq_id & ~r_lu_seen & (r_state != S_LU);
    assign w_mc_en  = (w_next == S_MC);

    always_comb begin
        w_stall = STALL_NONE;
        w_next  = r_state;
        if (!rst) begin
            w_stall = STALL_NONE;
        end else if (bus.stallreq_ex) begin
            w_stall = STALL_MC;
        end else if (w_id_req) begin
            w_stall = STALL_LU;
        end
        unique case (r_state)
            S_RUN: begin
                if (bus.stallreq_ex) w_next = S_MC;
                else if (w_id_req)   w_next = S_LU;
                else                 w_next = S_RUN;
            end
            S_LU:    w_next = bus.stallreq_ex ? S_MC : S_RUN;
            S_MC:    w_next = bus.stallreq_ex ? S_MC : S_RUN;
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_RUN;
            r_lu_seen <= 1'b0;
            r_inslot  <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_lu_seen <= bus.stallreq_id
                       & (r_lu_seen | (w_stall == STALL_LU));
            if (w_stall[1] == NO_STOP) begin
                r_inslot <= bus.next_is_indelayslot & ~w_stall[2];
            end
            if (w_mc_en && (w_mc_cnt >= MC_LAST)) begin
                r_to <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W   (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_stall[0] == STOP),
        .i_clr (1'b0),
        .o_cnt (w_stall_cnt)
    );

    sat_counter #(
        .W   (MC_W),
        .MAX (MC_TOP)
    ) u_mc_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_mc_en),
        .i_clr (~w_mc_en),
        .o_cnt (w_mc_cnt)
    );

    // Held ID must not redirect; the branch re-resolves on release
    assign w_br = rst & bus.br_e_i & ~w_stall[2];

    assign bus.stall          = w_stall;
    assign bus.br_e_o         = w_br;
    assign bus.br_addr_o      = w_br ? bus.br_addr_i : 32'h0;
    assign bus.is_indelayslot = r_inslot;
    assign bus.stall_cnt      = w_stall_cnt;
    assign bus.mc_timeout     = r_to;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a cycle-level reference
// model and per-cycle output comparison.
module tb_pipe_stall_ctrl;

    localparam int CNT_W  = 8;
    localparam int MC_MAX = 8;
    localparam int CNT_TOP = (2 ** CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(
        .STALL_W (6),
        .CNT_W   (CNT_W),
        .MC_MAX  (MC_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: served = current ID request already got its bubble
    bit m_served;
    bit m_slot;
    bit m_to;
    int m_cnt;
    int m_run;
    logic [31:0] addr_seed = 32'h0000_1000;

    function automatic logic [5:0] m_stall();
        if (!rst) return 6'b000000;
        if (bus.stallreq_ex) return 6'b001111;
        if (bus.stallreq_id && !m_served) return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_served = 1'b0;
            m_slot   = 1'b0;
            m_to     = 1'b0;
            m_cnt    = 0;
            m_run    = 0;
        end else begin
            logic [5:0] s;
            s = m_stall();
            if (s[0] && (m_cnt < CNT_TOP)) m_cnt++;
            if (!s[1]) m_slot = bus.next_is_indelayslot;
            m_run = bus.stallreq_ex ? m_run + 1 : 0;
            if (m_run >= MC_MAX) m_to = 1'b1;
            m_served = bus.stallreq_id && (m_served || (s == 6'b000111));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            logic [5:0] s;
            logic       b;
            s = m_stall();
            b = bus.br_e_i & ~s[2];
            chk("stall", bus.stall, s);
            chk("br_e_o", bus.br_e_o, b);
            chk("br_addr_o", bus.br_addr_o, b ? bus.br_addr_i : 32'h0);
            chk("is_indelayslot", bus.is_indelayslot, m_slot);
            chk("stall_cnt", bus.stall_cnt, m_cnt);
            chk("mc_timeout", bus.mc_timeout, m_to);
        end
    end

    task automatic step(input bit ex, input bit id, input bit br,
                        input bit nds);
        @(posedge clk);
        #1;
        bus.stallreq_ex         = ex;
        bus.stallreq_id         = id;
        bus.br_e_i              = br;
        addr_seed               = addr_seed + 32'h4;
        bus.br_addr_i           = addr_seed;
        bus.next_is_indelayslot = nds;
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_ex         = 1'b0;
        bus.stallreq_id         = 1'b0;
        bus.br_e_i              = 1'b0;
        bus.br_addr_i           = 32'h0;
        bus.next_is_indelayslot = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.br_e_i = 1'b1;
        bus.br_addr_i = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.stall, 6'b000000);
        chk("rst_br_e_o", bus.br_e_o, 1'b0);
        chk("rst_br_addr", bus.br_addr_o, 32'h0);
        do_reset();

        for (int i = 0; i < 10; i++) step(0, 0, i[0], 0);
        chk("idle_stall", bus.stall, 6'b000000);
        chk("idle_cnt", bus.stall_cnt, 8'd0);
        chk("idle_slot", bus.is_indelayslot, 1'b0);
        chk("idle_br", bus.br_e_o, 1'b1);

        do_reset();
        step(0, 1, 1, 0);
        chk("lu_stall", bus.stall, 6'b000111);
        chk("lu_br_gated", bus.br_e_o, 1'b0);
        step(0, 1, 1, 0);
        chk("lu_2nd", bus.stall, 6'b000000);
        chk("lu_br_open", bus.br_e_o, 1'b1);
        step(0, 1, 1, 0);
        chk("lu_3rd", bus.stall, 6'b000000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lu_cnt", bus.stall_cnt, 8'd1);

        do_reset();
        step(1, 0, 1, 0);
        chk("mc_c1", bus.stall, 6'b001111);
        chk("mc_br_gated", bus.br_e_o, 1'b0);
        step(1, 1, 0, 0);
        chk("mc_c2", bus.stall, 6'b001111);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mc_c5", bus.stall, 6'b001111);
        step(0, 0, 0, 0);
        chk("mc_release", bus.stall, 6'b000000);
        step(0, 0, 0, 0);
        chk("mc_cnt", bus.stall_cnt, 8'd5);
        chk("mc_no_to", bus.mc_timeout, 1'b0);

        do_reset();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("ds_set", bus.is_indelayslot, 1'b1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ds_held", bus.is_indelayslot, 1'b1);
        step(0, 0, 0, 0);
        chk("ds_clear", bus.is_indelayslot, 1'b0);

        do_reset();
        for (int i = 1; i <= MC_MAX + 3; i++) begin
            step(1, 0, 0, 0);
            if (i == MC_MAX) chk("to_before", bus.mc_timeout, 1'b0);
            if (i == MC_MAX + 1) chk("to_rise", bus.mc_timeout, 1'b1);
        end
        repeat (3) step(0, 0, 0, 0);
        chk("to_sticky", bus.mc_timeout, 1'b1);
        chk("to_stall_cnt", bus.stall_cnt, MC_MAX + 3);

        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_stall", bus.stall, 6'b000000);
        chk("arst_br", bus.br_e_o, 1'b0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0);
        chk("arst_cnt", bus.stall_cnt, 8'd0);
        chk("arst_to", bus.mc_timeout, 1'b0);

        for (int i = 0; i < CNT_TOP + 5; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("sat_cnt", bus.stall_cnt, CNT_TOP);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("sat_hold", bus.stall_cnt, CNT_TOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
